fetch_stage: RTL

//  IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; directly upstream of the decode Controller.

---
 rtl/fetch_stage.sv | 74 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: PC, async-ROM fetch, j/beq/bne redirect with a one-bubble squash; 1-cycle fetch-to-ID latency.
// Backpressure: stall freezes PC, IF/ID and counters; a held redirect is re-evaluated once stall drops.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             jumpSel,
    input  logic             jumpCondSel,
    output logic [31:0]      id_instr,
    output logic [5:0]       id_opcode,
    output logic [5:0]       id_func,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0] pc;
    ifid_t       ifid;
    logic [31:0] pc_seq;
    logic [31:0] jtarget;
    logic [31:0] btarget;
    logic        redirect;

    // Fetch address comes straight from the PC register, never from control inputs.
    assign imem_addr = pc;
    assign pc_seq    = pc + 32'd4;

    assign jtarget  = {ifid.pc4[31:28], ifid.instr[25:0], 2'b00};
    assign btarget  = ifid.pc4 + {{14{ifid.instr[15]}}, ifid.instr[15:0], 2'b00};
    assign redirect = (jumpSel | jumpCondSel) & ifid.valid;

    assign id_instr  = ifid.instr;
    assign id_opcode = ifid.instr[31:26];
    assign id_func   = ifid.instr[5:0];
    assign id_pc4    = ifid.pc4;
    assign id_valid  = ifid.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ifid      <= '0;
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else if (!stall) begin
            if (redirect) begin
                // Wrong-path fetch is dropped; IF/ID becomes an all-zero NOP bubble.
                pc        <= jumpSel ? jtarget : btarget;
                ifid      <= '0;
                flush_cnt <= flush_cnt + CNT_ONE;
            end else begin
                pc         <= pc_seq;
                ifid.instr <= imem_rdata;
                ifid.pc4   <= pc_seq;
                ifid.valid <= 1'b1;
                fetch_cnt  <= fetch_cnt + CNT_ONE;
            end
        end
    end

endmodule
